// File: rtl/tcam_rule_loader_pkg.sv
// rtl/tcam_rule_loader_pkg.sv - shared opcodes, state encoding and index width for the TCAM rule loader
package tcam_rule_loader_pkg;

    localparam int ENTRIES_DEFAULT = 16;
    localparam int IDX_W           = $clog2(ENTRIES_DEFAULT);

    localparam logic [1:0] OP_INSTALL = 2'b00;
    localparam logic [1:0] OP_CLEAR   = 2'b01;
    localparam logic [1:0] OP_VAL     = 2'b10;
    localparam logic [1:0] OP_MSK     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_VAL  = 3'd1,
        ST_WR_MSK  = 3'd2,
        ST_CLR_VAL = 3'd3,
        ST_CLR_MSK = 3'd4
    } state_t;

endpackage

// File: rtl/tcam_rule_loader.sv
// rtl/tcam_rule_loader.sv - sequences rule commands into single-cycle TCAM value/mask write beats
module tcam_rule_loader
    import tcam_rule_loader_pkg::*;
#(
    parameter int KEY_W   = 128,
    parameter int ENTRIES = ENTRIES_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(ENTRIES)-1:0] cmd_addr,
    input  logic [KEY_W-1:0]           cmd_value,
    input  logic [KEY_W-1:0]           cmd_mask,
    output logic                       wr_en,
    output logic                       wr_is_mask,
    output logic [$clog2(ENTRIES)-1:0] wr_addr,
    output logic [KEY_W-1:0]           wr_data,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           install_cnt
);

    localparam int ADDR_W = $clog2(ENTRIES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

    state_t            state;
    logic [1:0]        op_q;
    logic [KEY_W-1:0]  mask_q;

    // During clear-all the registered wr_addr doubles as the entry index counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_INSTALL;
            mask_q      <= '0;
            cmd_ready   <= 1'b0;
            wr_en       <= 1'b0;
            wr_is_mask  <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            install_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wr_en     <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        mask_q    <= cmd_mask;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        wr_en     <= 1'b1;
                        case (cmd_op)
                            OP_CLEAR: begin
                                state      <= ST_CLR_VAL;
                                wr_addr    <= '0;
                                wr_data    <= '0;
                                wr_is_mask <= 1'b0;
                            end
                            OP_MSK: begin
                                state      <= ST_WR_MSK;
                                wr_addr    <= cmd_addr;
                                wr_data    <= cmd_mask;
                                wr_is_mask <= 1'b1;
                            end
                            default: begin
                                state      <= ST_WR_VAL;
                                wr_addr    <= cmd_addr;
                                wr_data    <= cmd_value;
                                wr_is_mask <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_WR_VAL: begin
                    if (op_q == OP_INSTALL) begin
                        state      <= ST_WR_MSK;
                        wr_is_mask <= 1'b1;
                        wr_data    <= mask_q;
                    end else begin
                        state      <= ST_IDLE;
                        wr_en      <= 1'b0;
                        wr_is_mask <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cmd_ready  <= 1'b1;
                    end
                end
                ST_WR_MSK: begin
                    if (op_q == OP_INSTALL && install_cnt != '1) begin
                        install_cnt <= install_cnt + CNT_W'(1);
                    end
                    state      <= ST_IDLE;
                    wr_en      <= 1'b0;
                    wr_is_mask <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    cmd_ready  <= 1'b1;
                end
                ST_CLR_VAL: begin
                    state      <= ST_CLR_MSK;
                    wr_is_mask <= 1'b1;
                end
                ST_CLR_MSK: begin
                    if (wr_addr == LAST_IDX) begin
                        state       <= ST_IDLE;
                        wr_addr     <= '0;
                        wr_en       <= 1'b0;
                        wr_is_mask  <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cmd_ready   <= 1'b1;
                        install_cnt <= '0;
                    end else begin
                        state      <= ST_CLR_VAL;
                        wr_addr    <= wr_addr + ADDR_W'(1);
                        wr_is_mask <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    wr_en     <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_rule_loader.sv
// tb/tb_tcam_rule_loader.sv - randomized self-checking bench for tcam_rule_loader against a beat-list model
module tb_tcam_rule_loader;
    import tcam_rule_loader_pkg::*;

    localparam int KEY_W   = 128;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;
    localparam int AW      = $clog2(ENTRIES);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [AW-1:0]    cmd_addr = '0;
    logic [KEY_W-1:0] cmd_value = '0;
    logic [KEY_W-1:0] cmd_mask = '0;
    logic             wr_en;
    logic             wr_is_mask;
    logic [AW-1:0]    wr_addr;
    logic [KEY_W-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] install_cnt;

    tcam_rule_loader #(.KEY_W(KEY_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_mask(cmd_mask),
        .wr_en(wr_en), .wr_is_mask(wr_is_mask), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .install_cnt(install_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             m;
        logic [AW-1:0]    a;
        logic [KEY_W-1:0] d;
    } beat_t;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    int cnt_max = (1 << CNT_W) - 1;

    task automatic chk(input string tag, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after reset recovery).
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [KEY_W-1:0] val, input logic [KEY_W-1:0] msk,
                           input bit keep, input int abort_beat, input bit expect_now);
        beat_t exp_q[$];
        beat_t b;
        int waits;
        exp_q.delete();
        case (op)
            OP_INSTALL: begin
                b.m = 1'b0; b.a = addr; b.d = val; exp_q.push_back(b);
                b.m = 1'b1; b.a = addr; b.d = msk; exp_q.push_back(b);
            end
            OP_VAL: begin b.m = 1'b0; b.a = addr; b.d = val; exp_q.push_back(b); end
            OP_MSK: begin b.m = 1'b1; b.a = addr; b.d = msk; exp_q.push_back(b); end
            default: begin
                for (int i = 0; i < ENTRIES; i++) begin
                    b.m = 1'b0; b.a = AW'(i); b.d = '0; exp_q.push_back(b);
                    b.m = 1'b1; exp_q.push_back(b);
                end
            end
        endcase

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_value = val;
        cmd_mask  = msk;
        waits = 0;
        while (!cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            chk("accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (expect_now) chk("accept_wait", waits, 0);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;

        for (int i = 0; i < exp_q.size(); i++) begin
            chk("beat_wr_en", wr_en, 1'b1);
            chk("beat_is_mask", wr_is_mask, exp_q[i].m);
            chk("beat_addr", wr_addr, exp_q[i].a);
            chk("beat_data", wr_data, exp_q[i].d);
            chk("beat_busy", busy, 1'b1);
            chk("beat_ready", cmd_ready, 1'b0);
            chk("beat_done", done, 1'b0);
            if (i + 1 == abort_beat) begin
                rst = 1'b1;
                cmd_valid = 1'b0;
                @(negedge clk);
                model_cnt = 0;
                chk("abort_wr_en", wr_en, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_cnt", install_cnt, model_cnt);
                chk("abort_ready", cmd_ready, 1'b0);
                rst = 1'b0;
                @(negedge clk);
                chk("abort_ready_rise", cmd_ready, 1'b1);
                chk("abort_no_done", done, 1'b0);
                return;
            end
            @(negedge clk);
        end

        if (op == OP_INSTALL) model_cnt = (model_cnt < cnt_max) ? model_cnt + 1 : cnt_max;
        else if (op == OP_CLEAR) model_cnt = 0;
        chk("done_pulse", done, 1'b1);
        chk("done_wr_en", wr_en, 1'b0);
        chk("done_ready", cmd_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_cnt", install_cnt, model_cnt);
    endtask

    initial begin
        logic [1:0] op;
        int gap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_is_mask", wr_is_mask, 1'b0);
        chk("rst_addr", wr_addr, '0);
        chk("rst_data", wr_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt", install_cnt, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1'b1);

        run_cmd(OP_INSTALL, AW'(5), 128'hA5, 128'h0F, 1'b0, 0, 1'b1);
        run_cmd(OP_VAL, AW'(15), rand_key(), rand_key(), 1'b0, 0, 1'b1);
        run_cmd(OP_MSK, AW'(0), rand_key(), rand_key(), 1'b0, 0, 1'b1);
        run_cmd(OP_CLEAR, AW'(9), rand_key(), rand_key(), 1'b0, 0, 1'b1);

        for (int i = 0; i < 3; i++)
            run_cmd(OP_INSTALL, AW'($urandom_range(0, ENTRIES - 1)), rand_key(), rand_key(), 1'b1, 0, 1'b1);
        cmd_valid = 1'b0;
        @(negedge clk);

        run_cmd(OP_CLEAR, AW'(0), rand_key(), rand_key(), 1'b0, 7, 1'b1);

        for (int i = 0; i < 17; i++)
            run_cmd(OP_INSTALL, AW'($urandom_range(0, ENTRIES - 1)), rand_key(), rand_key(), 1'b0, 0, 1'b1);
        chk("sat_cnt", install_cnt, 4'hF);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_CLEAR && $urandom_range(0, 2) != 0) op = OP_INSTALL;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                cmd_valid = 1'b0;
                repeat (gap) @(negedge clk);
                chk("idle_wr_en", wr_en, 1'b0);
            end
            run_cmd(op, AW'($urandom_range(0, ENTRIES - 1)), rand_key(), rand_key(),
                    1'($urandom_range(0, 1)), 0, 1'b1);
        end
        cmd_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcam_rule_loader.md
Name: tcam_rule_loader

Overview:
Control-plane writer for the data-plane TCAM's write port (wr_en / wr_is_mask / wr_addr / wr_data).
- Accepts rule commands over a valid/ready handshake.
- Sequences each command into one or more single-cycle TCAM write beats.
- Provides a table-busy indication and a completion pulse.
- Sits between the control-plane register/CSR interface and the TCAM lookup block.

Parameters:
KEY_W, 128, key/value/mask width in bits; must equal the TCAM's KEY_W.
ENTRIES, 16, number of TCAM entries; power of two, at least 2.
CNT_W, 16, width of the install counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  loader can accept a command
cmd_op  in  2  00 install (value+mask), 01 clear-all, 10 value-only, 11 mask-only
cmd_addr  in  $clog2(ENTRIES)  target entry; ignored for clear-all
cmd_value  in  KEY_W  rule value
cmd_mask  in  KEY_W  rule mask (1 = don't care)
wr_en  out  1  TCAM write strobe
wr_is_mask  out  1  0 = value beat, 1 = mask beat
wr_addr  out  $clog2(ENTRIES)  TCAM entry address
wr_data  out  KEY_W  TCAM write data
busy  out  1  high while a command is in progress (state != IDLE)
done  out  1  one-cycle pulse after the final write beat of a command
install_cnt  out  CNT_W  completed install commands, saturating

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: cmd_ready=0, wr_en=0, wr_is_mask=0, wr_addr=0, wr_data=0, busy=0, done=0, install_cnt=0, state=IDLE.
- cmd_ready rises the first cycle after rst deasserts.
- States: IDLE, WR_VAL, WR_MSK, CLR_VAL, CLR_MSK.
- Handshake:
  - A command is accepted on a clock edge where cmd_valid && cmd_ready.
  - All cmd_* fields are latched at that edge.
  - cmd_ready drops in the cycle after acceptance and stays low until the done cycle.
  - cmd_valid while cmd_ready=0 is ignored; the loader does not buffer.
- Install (op 00): accept at edge T, then:
  - cycle T+1: WR_VAL beat (wr_en=1, wr_is_mask=0, wr_data=value).
  - cycle T+2: WR_MSK beat (wr_en=1, wr_is_mask=1, wr_data=mask).
  - cycle T+3: IDLE with done=1, cmd_ready=1, install_cnt+1.
  - Value is always written before mask.
- Value-only (op 10) and mask-only (op 11): a single beat at T+1, done and ready at T+2. install_cnt is unchanged.
- Clear-all (op 01):
  - For idx = 0 .. ENTRIES-1 ascending: CLR_VAL beat (value 0), then CLR_MSK beat (mask 0), at wr_addr=idx.
  - 2*ENTRIES consecutive beats with no gaps.
  - done in the cycle after the last beat.
  - install_cnt is set to 0 in the done cycle.
- wr_en is high only during beat states and is low in every other cycle, including the done cycle.
- install_cnt saturates at all-ones and does not wrap.
- The index counter wraps only at completion; after ENTRIES-1 it returns to IDLE and does not re-enter clear.
- A new command may be accepted in the done cycle itself, giving back-to-back installs every 3 cycles.
- Reset mid-command:
  - At the next edge the command aborts, wr_en=0, state=IDLE, and no done pulse is issued.
  - Any partially written TCAM entry is left as-is; control software must re-issue the command.
- busy is high from T+1 through the last beat. The data plane may gate key_valid with it.

Decomposition:
- Shared package:
  - opcode constants OP_INSTALL=2'b00, OP_CLEAR=2'b01, OP_VAL=2'b10, OP_MSK=2'b11.
  - state encoding.
  - IDX_W = $clog2(ENTRIES), shared with the TCAM block.
- No sub-module: a single FSM with an index counter and an output register stage.

Test Plan:
- Install, op=00, addr=5, value=128'hA5, mask=128'h0F, accepted at T -> T+1: wr_en=1, wr_is_mask=0, addr=5, data=A5. T+2: wr_is_mask=1, data=0F. T+3: done=1, cmd_ready=1, install_cnt=1.
- Clear-all with ENTRIES=16 -> 32 consecutive beats with addr 0,0,1,1..15,15, alternating wr_is_mask 0/1 and data=0. done at beat 33. install_cnt=0.
- Back-to-back: cmd_valid held high with 3 install commands -> accepts every 3 cycles, 6 write beats total, install_cnt=3, cmd_ready never high during beats.
- Value-only op=10, addr=15 -> single beat with wr_is_mask=0, addr=15. done next cycle. install_cnt unchanged.
- Reset asserted during clear-all beat 7 -> next cycle wr_en=0, busy=0, done=0, install_cnt=0. cmd_ready=1 one cycle after rst deasserts.
- Saturation: preload via 2^CNT_W-1 installs (use CNT_W=4 build, 15 installs), then one more install -> install_cnt stays 4'hF.
